// File: rtl/cache_controller.sv
// cache_controller
//
// Sequencing controller for a 4-way fully associative, one-word-per-line,
// write-back cache with a 7-bit address and 8-bit data. It takes one CPU
// request at a time and owns every piece of line metadata (tag, valid,
// dirty, LRU age). The data arrays, the RAM and the data muxes live outside
// this block. This block drives their selects, write enables and strobes.
//
// Parameters
//   RAM_LAT   cycles from ram_rd to RAM data valid (legal range 1..7)
//
// Ports
//   clock     system clock, rising edge
//   resetn    asynchronous active-low reset
//   req       CPU request, sampled only while ready=1
//   req_wren  1 = write, 0 = read
//   req_addr  request address, used as the full tag
//   ready     controller idle and able to accept a request
//   done      one-cycle completion pulse
//   hit_flag  valid with done: 1 = hit, 0 = miss
//   way_sel   way index for the data-array read/output mux
//   way_wren  one-hot data-array write enable
//   way_src   fill-mux select: 0 = CPU data, 1 = RAM data
//   ram_addr  RAM address
//   ram_rd    RAM read strobe
//   ram_wr    RAM write strobe, data taken from way way_sel
//
// Every output is decoded from registered state only, so all outputs are
// Moore outputs and carry no combinational path from the request inputs.
module cache_controller #(
    parameter int RAM_LAT = 1
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       req,
    input  logic       req_wren,
    input  logic [6:0] req_addr,
    output logic       ready,
    output logic       done,
    output logic       hit_flag,
    output logic [1:0] way_sel,
    output logic [3:0] way_wren,
    output logic       way_src,
    output logic [6:0] ram_addr,
    output logic       ram_rd,
    output logic       ram_wr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WRITEBACK,
        S_FILL_REQ,
        S_FILL_WAIT,
        S_FILL,
        S_DONE
    } state_e;

    typedef logic [3:0][1:0] ages_t;
    typedef logic [3:0][6:0] tags_t;

    localparam ages_t AGE_RST = {2'd3, 2'd2, 2'd1, 2'd0};

    state_e     state_q, state_d;
    logic [6:0] addr_q,  addr_d;
    logic       wren_q,  wren_d;
    tags_t      tag_q,   tag_d;
    logic [3:0] valid_q, valid_d;
    logic [3:0] dirty_q, dirty_d;
    ages_t      age_q,   age_d;
    logic [1:0] way_q,   way_d;    // way being accessed: hit way or victim
    logic       hit_q,   hit_d;
    logic [2:0] cnt_q,   cnt_d;    // RAM read latency countdown

    logic       hit_any;
    logic [1:0] hit_way;
    logic [1:0] miss_way;

    // Touching way w makes it the youngest. Every way that was younger than
    // w ages by one, so the ages stay a permutation of 0..3.
    function automatic ages_t lru_touch(input ages_t ages, input logic [1:0] w);
        ages_t r;
        r = ages;
        for (int i = 0; i < 4; i++) begin
            if (ages[i] < ages[w]) begin
                r[i] = ages[i] + 2'd1;
            end
        end
        r[w] = 2'd0;
        return r;
    endfunction

    // Tag match and victim choice. The victim is the lowest-index invalid
    // way, or the oldest way (age 3) when all ways are valid. The second
    // loop runs downward so that the lowest invalid index has the final
    // write.
    always_comb begin
        hit_any  = 1'b0;
        hit_way  = 2'd0;
        miss_way = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (valid_q[i] && (tag_q[i] == addr_q)) begin
                hit_any = 1'b1;
                hit_way = 2'(i);
            end
            if (age_q[i] == 2'd3) begin
                miss_way = 2'(i);
            end
        end
        for (int i = 3; i >= 0; i--) begin
            if (!valid_q[i]) begin
                miss_way = 2'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wren_d   = wren_q;
        tag_d    = tag_q;
        valid_d  = valid_q;
        dirty_d  = dirty_q;
        age_d    = age_q;
        way_d    = way_q;
        hit_d    = hit_q;
        cnt_d    = cnt_q;

        ready    = 1'b0;
        done     = 1'b0;
        hit_flag = 1'b0;
        way_sel  = 2'd0;
        way_wren = 4'd0;
        way_src  = 1'b0;
        ram_addr = 7'd0;
        ram_rd   = 1'b0;
        ram_wr   = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (req) begin
                    addr_d  = req_addr;
                    wren_d  = req_wren;
                    state_d = S_LOOKUP;
                end
            end

            S_LOOKUP: begin
                if (hit_any) begin
                    hit_d   = 1'b1;
                    way_d   = hit_way;
                    way_sel = hit_way;
                    age_d   = lru_touch(age_q, hit_way);
                    if (wren_q) begin
                        way_wren[hit_way] = 1'b1;
                        dirty_d[hit_way]  = 1'b1;
                    end
                    state_d = S_DONE;
                end else begin
                    hit_d = 1'b0;
                    way_d = miss_way;
                    if (valid_q[miss_way] && dirty_q[miss_way]) begin
                        state_d = S_WRITEBACK;
                    end else if (wren_q) begin
                        state_d = S_FILL;
                    end else begin
                        state_d = S_FILL_REQ;
                    end
                end
            end

            S_WRITEBACK: begin
                ram_wr         = 1'b1;
                ram_addr       = tag_q[way_q];
                way_sel        = way_q;
                dirty_d[way_q] = 1'b0;
                state_d        = wren_q ? S_FILL : S_FILL_REQ;
            end

            S_FILL_REQ: begin
                ram_rd   = 1'b1;
                ram_addr = addr_q;
                cnt_d    = 3'(RAM_LAT);
                state_d  = S_FILL_WAIT;
            end

            // Leaves after exactly RAM_LAT cycles in this state.
            S_FILL_WAIT: begin
                if (cnt_q <= 3'd1) begin
                    state_d = S_FILL;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            // A write miss allocates without reading RAM. The CPU word fills
            // the line and the line is dirty at once.
            S_FILL: begin
                way_wren[way_q] = 1'b1;
                way_sel         = way_q;
                way_src         = !wren_q;
                tag_d[way_q]    = addr_q;
                valid_d[way_q]  = 1'b1;
                dirty_d[way_q]  = wren_q;
                age_d           = lru_touch(age_q, way_q);
                state_d         = S_DONE;
            end

            S_DONE: begin
                done     = 1'b1;
                hit_flag = hit_q;
                way_sel  = way_q;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            addr_q  <= 7'd0;
            wren_q  <= 1'b0;
            tag_q   <= '0;
            valid_q <= 4'd0;
            dirty_q <= 4'd0;
            age_q   <= AGE_RST;
            way_q   <= 2'd0;
            hit_q   <= 1'b0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wren_q  <= wren_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            age_q   <= age_d;
            way_q   <= way_d;
            hit_q   <= hit_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Testbench for cache_controller. Instance A uses RAM_LAT=1 and instance B
// uses RAM_LAT=4. A transaction-level cache model predicts each output of
// both instances on every cycle. Directed literal expectations pin the key
// event cycles.
`timescale 1ns/1ps
module tb_cache_controller;

    typedef struct packed {
        logic       ready;
        logic       done;
        logic       hit;
        logic       chk_sel;
        logic [1:0] sel;
        logic [3:0] wren;
        logic       src;
        logic [6:0] addr;
        logic       rd;
        logic       wr;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       resetn;
    logic       req_a, wren_a, req_b, wren_b;
    logic [6:0] addr_a, addr_b;

    logic       ready_a, done_a, hit_a, src_a, rd_a, wr_a;
    logic [1:0] sel_a;
    logic [3:0] wen_a;
    logic [6:0] raddr_a;
    logic       ready_b, done_b, hit_b, src_b, rd_b, wr_b;
    logic [1:0] sel_b;
    logic [3:0] wen_b;
    logic [6:0] raddr_b;

    int checks = 0;
    int errors = 0;

    cache_controller #(.RAM_LAT(1)) u_dut_a (
        .clock(clock), .resetn(resetn), .req(req_a), .req_wren(wren_a), .req_addr(addr_a),
        .ready(ready_a), .done(done_a), .hit_flag(hit_a), .way_sel(sel_a), .way_wren(wen_a),
        .way_src(src_a), .ram_addr(raddr_a), .ram_rd(rd_a), .ram_wr(wr_a)
    );

    cache_controller #(.RAM_LAT(4)) u_dut_b (
        .clock(clock), .resetn(resetn), .req(req_b), .req_wren(wren_b), .req_addr(addr_b),
        .ready(ready_b), .done(done_b), .hit_flag(hit_b), .way_sel(sel_b), .way_wren(wen_b),
        .way_src(src_b), .ram_addr(raddr_b), .ram_rd(rd_b), .ram_wr(wr_b)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic exp_t get_act(input int k);
        exp_t o;
        o = '0;
        if (k == 0) begin
            o.ready = ready_a; o.done = done_a; o.hit = hit_a; o.sel = sel_a; o.wren = wen_a;
            o.src = src_a; o.addr = raddr_a; o.rd = rd_a; o.wr = wr_a;
        end else begin
            o.ready = ready_b; o.done = done_b; o.hit = hit_b; o.sel = sel_b; o.wren = wen_b;
            o.src = src_b; o.addr = raddr_b; o.rd = rd_b; o.wr = wr_b;
        end
        return o;
    endfunction

    // ---------------- cache model (owned by the compare process) ----------------
    logic [6:0] m_tag   [2][4];
    bit         m_val   [2][4];
    bit         m_dirty [2][4];
    int         m_age   [2][4];
    exp_t       q0[$];
    exp_t       q1[$];
    bit         cur_ready [2];

    function automatic exp_t idle_e();
        exp_t e;
        e = '0;
        e.ready = 1'b1;
        return e;
    endfunction

    task automatic push(input int k, input exp_t e);
        if (k == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic m_reset(input int k);
        for (int i = 0; i < 4; i++) begin
            m_tag[k][i] = 7'd0; m_val[k][i] = 0; m_dirty[k][i] = 0; m_age[k][i] = i;
        end
        if (k == 0) q0.delete(); else q1.delete();
        cur_ready[k] = 1'b1;
    endtask

    task automatic touch(input int k, input int w);
        int a;
        a = m_age[k][w];
        for (int i = 0; i < 4; i++) if (m_age[k][i] < a) m_age[k][i]++;
        m_age[k][w] = 0;
    endtask

    // Expected output per cycle, starting with the LOOKUP cycle.
    task automatic build(input int k, input logic w, input logic [6:0] a);
        int   h, v, lat;
        exp_t e;
        lat = (k == 0) ? 1 : 4;
        h = -1;
        for (int i = 0; i < 4; i++) if (m_val[k][i] && m_tag[k][i] == a) h = i;
        if (h >= 0) begin
            e = '0;
            if (w) e.wren = 4'(1 << h);
            else begin e.chk_sel = 1; e.sel = 2'(h); end
            push(k, e);
            touch(k, h);
            if (w) m_dirty[k][h] = 1;
            e = '0; e.done = 1; e.hit = 1; e.chk_sel = 1; e.sel = 2'(h);
            push(k, e);
        end else begin
            v = -1;
            for (int i = 0; i < 4; i++) if (m_age[k][i] == 3) v = i;
            for (int i = 3; i >= 0; i--) if (!m_val[k][i]) v = i;
            e = '0;
            push(k, e);
            if (m_val[k][v] && m_dirty[k][v]) begin
                e = '0; e.wr = 1; e.addr = m_tag[k][v]; e.chk_sel = 1; e.sel = 2'(v);
                push(k, e);
            end
            if (!w) begin
                e = '0; e.rd = 1; e.addr = a;
                push(k, e);
                e = '0;
                for (int i = 0; i < lat; i++) push(k, e);
            end
            e = '0; e.wren = 4'(1 << v); e.src = !w;
            push(k, e);
            m_tag[k][v] = a; m_val[k][v] = 1; m_dirty[k][v] = w;
            touch(k, v);
            e = '0; e.done = 1; e.hit = 0; e.chk_sel = 1; e.sel = 2'(v);
            push(k, e);
        end
    endtask

    task automatic compare(input int k, input exp_t e);
        exp_t a, x;
        a = get_act(k);
        x = e;
        x.chk_sel = 0;
        if (!e.done) begin a.hit = 0; x.hit = 0; end
        if (!e.chk_sel) begin a.sel = 0; x.sel = 0; end
        if (!(e.rd || e.wr)) begin a.addr = 0; x.addr = 0; end
        if (e.wren == 4'd0) begin a.src = 0; x.src = 0; end
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL cycle_model inst%0d @%0t: got %h required %h", k, $time, a, x);
        end
    endtask

    // Compare process: check on the falling edge, model acceptance on the rising edge.
    initial begin
        exp_t e;
        m_reset(0);
        m_reset(1);
        forever begin
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                if (!resetn) begin
                    m_reset(k);
                    e = idle_e();
                end else if (k == 0) begin
                    e = (q0.size() > 0) ? q0.pop_front() : idle_e();
                end else begin
                    e = (q1.size() > 0) ? q1.pop_front() : idle_e();
                end
                compare(k, e);
                cur_ready[k] = e.ready;
            end
            @(posedge clock);
            if (resetn) begin
                if (req_a && cur_ready[0]) build(0, wren_a, addr_a);
                if (req_b && cur_ready[1]) build(1, wren_b, addr_b);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    int         s_done_c, s_rd_c, s_wr_c, s_wren_c;
    logic       s_hit, s_src;
    logic [1:0] s_sel, s_wr_sel;
    logic [3:0] s_wren_v;
    logic [6:0] s_rd_addr, s_wr_addr;

    task automatic set_req(input int k, input logic r, input logic w, input logic [6:0] a);
        if (k == 0) begin req_a = r; wren_a = w; addr_a = a; end
        else begin req_b = r; wren_b = w; addr_b = a; end
    endtask

    // Issue one request and record the cycle (relative to the accept edge)
    // of each event. With hold=1 req stays high until done.
    task automatic run(input int k, input logic w, input logic [6:0] a, input bit hold);
        exp_t o;
        s_done_c = 0; s_rd_c = 0; s_wr_c = 0; s_wren_c = 0;
        s_hit = 0; s_src = 0; s_sel = 0; s_wr_sel = 0; s_wren_v = 0; s_rd_addr = 0; s_wr_addr = 0;
        @(negedge clock);
        set_req(k, 1'b1, w, a);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (!hold) set_req(k, 1'b0, w, a);
            o = get_act(k);
            if (o.rd && s_rd_c == 0) begin s_rd_c = c; s_rd_addr = o.addr; end
            if (o.wr && s_wr_c == 0) begin s_wr_c = c; s_wr_addr = o.addr; s_wr_sel = o.sel; end
            if (o.wren != 4'd0 && s_wren_c == 0) begin s_wren_c = c; s_wren_v = o.wren; s_src = o.src; end
            if (o.done) begin
                s_done_c = c; s_hit = o.hit; s_sel = o.sel;
                break;
            end
        end
        set_req(k, 1'b0, w, a);
    endtask

    initial begin
        logic [6:0] wr_addrs [3];
        logic [3:0] wr_ways  [3];
        wr_addrs = '{7'h10, 7'h11, 7'h12};
        wr_ways  = '{4'b0010, 4'b0100, 4'b1000};
        resetn = 1'b0;
        set_req(0, 1'b0, 1'b0, 7'd0);
        set_req(1, 1'b0, 1'b0, 7'd0);
        repeat (3) @(negedge clock);
        chk("rst_ready_a", ready_a, 1);
        chk("rst_outs_a", {done_a, hit_a, sel_a, wen_a, src_a, raddr_a, rd_a, wr_a}, 0);
        chk("rst_ready_b", ready_b, 1);
        #1 resetn = 1'b1;

        // Cold read miss, RAM_LAT=1
        run(0, 1'b0, 7'h05, 0);
        chk("cold_rd_cycle", s_rd_c, 2);
        chk("cold_rd_addr", s_rd_addr, 5);
        chk("cold_wren_cycle", s_wren_c, 4);
        chk("cold_wren_val", s_wren_v, 1);
        chk("cold_src", s_src, 1);
        chk("cold_done_cycle", s_done_c, 5);
        chk("cold_hit", s_hit, 0);

        // Read hit
        run(0, 1'b0, 7'h05, 0);
        chk("hit_done_cycle", s_done_c, 2);
        chk("hit_flag", s_hit, 1);
        chk("hit_sel", s_sel, 0);
        chk("hit_no_rd", s_rd_c, 0);
        chk("hit_no_wr", s_wr_c, 0);

        // Write misses allocate ways 1..3
        for (int i = 0; i < 3; i++) begin
            run(0, 1'b1, wr_addrs[i], 0);
            chk($sformatf("wmiss%0d_wren", i), s_wren_v, wr_ways[i]);
            chk($sformatf("wmiss%0d_fill_cycle", i), s_wren_c, 2);
            chk($sformatf("wmiss%0d_done_cycle", i), s_done_c, 3);
        end

        // Write hit on way 0
        run(0, 1'b1, 7'h05, 0);
        chk("whit_wren_cycle", s_wren_c, 1);
        chk("whit_wren_val", s_wren_v, 1);
        chk("whit_done_cycle", s_done_c, 2);
        chk("whit_hit", s_hit, 1);

        // Dirty eviction of way 1
        run(0, 1'b0, 7'h20, 0);
        chk("evict_wr_cycle", s_wr_c, 2);
        chk("evict_wr_addr", s_wr_addr, 'h10);
        chk("evict_wr_sel", s_wr_sel, 1);
        chk("evict_rd_cycle", s_rd_c, 3);
        chk("evict_rd_addr", s_rd_addr, 'h20);
        chk("evict_wren_cycle", s_wren_c, 5);
        chk("evict_wren_val", s_wren_v, 2);
        chk("evict_done_cycle", s_done_c, 6);

        // Busy and latency, RAM_LAT=4, req held high
        run(1, 1'b0, 7'h05, 1);
        chk("busy_rd_cycle", s_rd_c, 2);
        chk("busy_fill_cycle", s_wren_c, 7);
        chk("busy_done_cycle", s_done_c, 8);
        @(negedge clock);
        chk("busy_ready_after", ready_b, 1);
        chk("busy_no_extra_done", done_b, 0);
        run(1, 1'b0, 7'h05, 0);
        chk("lat4_hit_done_cycle", s_done_c, 2);
        chk("lat4_hit", s_hit, 1);

        // Reset in the middle of FILL_WAIT
        @(negedge clock);
        set_req(1, 1'b1, 1'b0, 7'h40);
        @(negedge clock);
        set_req(1, 1'b0, 1'b0, 7'h40);
        repeat (3) @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_ready", ready_b, 1);
        chk("midrst_outs", {done_b, hit_b, sel_b, wen_b, src_b, raddr_b, rd_b, wr_b}, 0);
        @(negedge clock);
        @(negedge clock);
        #1 resetn = 1'b1;
        run(1, 1'b0, 7'h05, 0);
        chk("post_rst_b_hit", s_hit, 0);
        chk("post_rst_b_done_cycle", s_done_c, 8);
        run(0, 1'b0, 7'h05, 0);
        chk("post_rst_a_hit", s_hit, 0);
        chk("post_rst_a_wren", s_wren_v, 1);

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cache_controller.md
# cache_controller

Sequencing controller for the 4-way fully associative, one-word-per-line, write-back cache (7-bit address, 8-bit data). It accepts one CPU request at a time and owns all cache metadata: tags, valid, dirty and LRU ages. It issues way select, write enables and fill-mux select to the four data arrays, and read/write strobes to the backing RAM with a parameterised read latency. It sits between the CPU request port and the existing way arrays, RAM and data muxes.

## Interface
- RAM_LAT, 1: cycles from `ram_rd` to RAM data valid; legal range is 1..7.
- clock  in  1  system clock; rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req  in  1  CPU request; sampled only while `ready`=1.
- req_wren  in  1  1 = write, 0 = read.
- req_addr  in  7  request address, used as the full tag.
- ready  out  1  controller in IDLE and able to accept a request.
- done  out  1  one-cycle pulse when the request completes.
- hit_flag  out  1  valid with `done`: 1 = hit, 0 = miss.
- way_sel  out  2  way index for the data-array read/output mux.
- way_wren  out  4  one-hot data-array write enable.
- way_src  out  1  fill-mux select: 0 = CPU data, 1 = RAM data.
- ram_addr  out  7  RAM address.
- ram_rd  out  1  RAM read strobe, one cycle.
- ram_wr  out  1  RAM write strobe, one cycle; data comes from way `way_sel`.

## Operation
- **Metadata:** per way `tag[6:0]`, `valid`, `dirty`, `age[1:0]`. Ages are always a permutation of 0..3.
- **Reset values:**
  - valid=0, dirty=0, tag=0, age[i]=i.
  - ready=1; all other outputs 0; state IDLE.
- **State machine:** IDLE, LOOKUP, WRITEBACK, FILL_REQ, FILL_WAIT, FILL, DONE.
- **IDLE:** `ready`=1. On `req`, latch `req_addr`/`req_wren` and go to LOOKUP. Requests in any other state are ignored.
- **LOOKUP:** hit = valid & tag==addr (at most one way matches).
  - Read hit: `way_sel`=hit way, go to DONE.
  - Write hit: `way_wren`[hit]=1, `way_src`=0, dirty[hit]=1, go to DONE.
  - Miss victim: the lowest-index invalid way; if all ways are valid, the way with age 3.
  - Miss with victim valid & dirty: go to WRITEBACK.
  - Other miss: write goes to FILL, read goes to FILL_REQ.
- **WRITEBACK:** `ram_wr`=1, `ram_addr`=victim tag, `way_sel`=victim, clear dirty[victim]. Then write goes to FILL, read goes to FILL_REQ.
- **FILL_REQ:** `ram_rd`=1, `ram_addr`=latched addr; load the wait counter with RAM_LAT; go to FILL_WAIT.
- **FILL_WAIT:** decrement once per cycle; stays exactly RAM_LAT cycles, then go to FILL.
- **FILL:**
  - `way_wren`[victim]=1, tag=addr, valid=1.
  - Read: `way_src`=1, dirty=0.
  - Write (write-allocate, no RAM read): `way_src`=0, dirty=1.
  - Go to DONE.
- **DONE:** `done`=1, `hit_flag` registered from LOOKUP, `way_sel` holds the accessed way (read data valid on the array output). Go to IDLE.
- **LRU update:** one update per request, in the LOOKUP cycle for a hit or the FILL cycle for a miss. For accessed way w with old age a: every way with age < a increments, and age[w]=0.
- **Strobes:** `way_wren`, `ram_rd`, `ram_wr` are zero outside the states listed above; never more than one `way_wren` bit high.
- **Reset mid-operation:** immediate return to reset values. A pending RAM read is abandoned and all lines are invalidated.

## Timing
- Accept edge = cycle 0 (req & ready). LOOKUP is cycle 1. Registered Moore outputs.
- **Read hit:** `done` in cycle 2.
- **Write hit:** `done` in cycle 2; `way_wren` in cycle 1.
- **Clean read miss:**
  - `ram_rd` in cycle 2.
  - FILL in cycle 3+RAM_LAT.
  - `done` in cycle 4+RAM_LAT.
- **Dirty read miss:** `ram_wr` in cycle 2; every later event shifts by +1.
- **Write miss:** FILL in cycle 2 (clean) or 3 (dirty); `done` one cycle after FILL.
- **`ready`:** low from cycle 1 through the DONE cycle; high the cycle after `done`.

## Test plan
- **Cold read miss:** reset, RAM_LAT=1, read 0x05.
  - `ram_rd`=1 with `ram_addr`=0x05 in cycle 2.
  - `way_wren`=0001 and `way_src`=1 in cycle 4.
  - `done`=1 with `hit_flag`=0 in cycle 5.
- **Read hit:** read 0x05 again.
  - `done` in cycle 2, `hit_flag`=1, `way_sel`=0.
  - No `ram_rd`/`ram_wr`.
- **Dirty eviction:** write 0x10, 0x11, 0x12 (misses allocate ways 1, 2, 3, dirty), then write 0x05 (hit, way 0). Then read 0x20.
  - Victim is way 1 (age 3).
  - `ram_wr` with `ram_addr`=0x10 and `way_sel`=1 in cycle 2.
  - `ram_rd` with `ram_addr`=0x20 in cycle 3.
  - `way_wren`=0010 in cycle 5; `done` in cycle 6.
- **Busy and latency:** with RAM_LAT=4, assert `req` continuously during a miss.
  - Extra requests are ignored.
  - FILL_WAIT lasts 4 cycles; `done` in cycle 8.
- **Reset mid-FILL_WAIT:** drop `resetn`.
  - All outputs go to 0 and `ready` goes to 1 immediately.
  - A following read of 0x05 misses (`hit_flag`=0).
